// File: rtl/egress_arbiter.sv
// egress_arbiter: per-output-port round-robin arbiter.
// Captures headers addressed to PORT_ID from every input, grants one input at a
// time, and forwards its data stream one register stage later until the packet's
// full beat count has passed. A grant with no data for TIMEOUT cycles is aborted.
module egress_arbiter #(
  parameter int N_PORTS = 16,
  parameter int PORT_ID = 0,
  parameter int TIMEOUT = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_PORTS-1:0]     in_new_packet,
  input  logic [4*N_PORTS-1:0]   in_dest_port,
  input  logic [9*N_PORTS-1:0]   in_length,
  input  logic [N_PORTS-1:0]     in_data_vld,
  input  logic [16*N_PORTS-1:0]  in_data,
  output logic [N_PORTS-1:0]     xfer_stop,
  output logic [N_PORTS-1:0]     grant,
  output logic                   out_vld,
  output logic [15:0]            out_data,
  output logic                   pkt_done,
  output logic                   pkt_abort
);

  localparam int PTR_W  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ARB, XFER} state_t;

  state_t             state;
  logic [N_PORTS-1:0] pending;
  logic [8:0]         len_tab [N_PORTS];
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   gnt_idx;
  logic [8:0]         beat_cnt;
  logic [IDLE_W-1:0]  idle_cnt;

  logic [N_PORTS-1:0] set_vec;
  logic [N_PORTS-1:0] clr_vec;
  logic [PTR_W-1:0]   sel_idx;
  logic [PTR_W-1:0]   rr_next;
  logic               g_vld;
  logic [15:0]        g_data;
  logic [8:0]         g_len;
  logic               finish_now;
  logic               abort_now;

  // Decode which inputs announce a packet for this output this cycle
  always_comb begin
    set_vec = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      set_vec[i] = in_new_packet[i] && (in_dest_port[4*i +: 4] == 4'(PORT_ID));
    end
  end

  // Round-robin search: first pending input at or after rr_ptr, wrapping
  always_comb begin
    int   idx;
    logic found;
    idx     = 0;
    found   = 1'b0;
    sel_idx = rr_ptr;
    for (int k = 0; k < N_PORTS; k++) begin
      idx = (int'(rr_ptr) + k) % N_PORTS;
      if (!found && pending[idx]) begin
        found   = 1'b1;
        sel_idx = PTR_W'(idx);
      end
    end
  end

  // Granted input's stream, end-of-packet and timeout conditions
  always_comb begin
    g_vld      = in_data_vld[gnt_idx];
    g_data     = in_data[16*int'(gnt_idx) +: 16];
    g_len      = len_tab[gnt_idx];
    finish_now = (state == XFER) && g_vld && (beat_cnt == g_len);
    abort_now  = (state == XFER) && !g_vld && (idle_cnt == IDLE_W'(TIMEOUT - 1));
    clr_vec    = (finish_now || abort_now) ? (N_PORTS'(1) << gnt_idx) : '0;
    rr_next    = PTR_W'((int'(gnt_idx) + 1) % N_PORTS);
  end

  // Pending requests: a new header wins over the clear of a finishing packet
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clr_vec) | set_vec;
    end
  end

  // Latch each accepted header's length; data-only storage, no reset needed
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_PORTS; i++) begin
      if (set_vec[i]) len_tab[i] <= in_length[9*i +: 9];
    end
  end

  // Arbitration / transfer FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      gnt_idx   <= '0;
      beat_cnt  <= '0;
      idle_cnt  <= '0;
      xfer_stop <= '1;
      grant     <= '0;
      out_vld   <= 1'b0;
      out_data  <= '0;
      pkt_done  <= 1'b0;
      pkt_abort <= 1'b0;
    end else begin
      pkt_done  <= 1'b0;
      pkt_abort <= 1'b0;
      case (state)
        IDLE: begin
          out_vld <= 1'b0;
          if (|pending) state <= ARB;
        end
        ARB: begin
          out_vld   <= 1'b0;
          gnt_idx   <= sel_idx;
          grant     <= N_PORTS'(1) << sel_idx;
          xfer_stop <= ~(N_PORTS'(1) << sel_idx);
          beat_cnt  <= '0;
          idle_cnt  <= '0;
          state     <= XFER;
        end
        XFER: begin
          if (g_vld) begin
            out_data <= g_data;
            out_vld  <= 1'b1;
            beat_cnt <= beat_cnt + 9'd1;
            idle_cnt <= '0;
            if (finish_now) begin
              pkt_done  <= 1'b1;
              xfer_stop <= '1;
              grant     <= '0;
              rr_ptr    <= rr_next;
              state     <= IDLE;
            end
          end else begin
            out_vld <= 1'b0;
            if (abort_now) begin
              pkt_abort <= 1'b1;
              xfer_stop <= '1;
              grant     <= '0;
              rr_ptr    <= rr_next;
              state     <= IDLE;
            end else begin
              idle_cnt <= idle_cnt + IDLE_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
